// File: rtl/gpio_register_if.sv
// Bus-side connection between the GPIO slave front end and the register file.
interface gpio_register_if;
    logic [31:0] gpio_addr;
    logic [31:0] gpio_dat_i;
    logic        gpio_we;
    logic [31:0] gpio_dat_o;
    logic        gpio_inta_o;

    modport master (
        output gpio_addr,
        output gpio_dat_i,
        output gpio_we,
        input  gpio_dat_o,
        input  gpio_inta_o
    );

    modport slave (
        input  gpio_addr,
        input  gpio_dat_i,
        input  gpio_we,
        output gpio_dat_o,
        output gpio_inta_o
    );
endinterface

// File: rtl/gpio_register.sv
// GPIO register file and pad logic: output mux, strobed input sampling
// and edge-triggered interrupt latching.
module gpio_register (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    gpio_register_if.slave         bus,
    input  logic                   gpio_eclk,
    input  logic [31:0]            in_pad_i,
    input  logic [31:0]            aux_i,
    output logic [31:0]            out_pad_o,
    output logic [31:0]            oen_padoe_o
);
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 6;

    localparam logic [AW-1:0] A_IN    = 6'h00;
    localparam logic [AW-1:0] A_OUT   = 6'h04;
    localparam logic [AW-1:0] A_OE    = 6'h08;
    localparam logic [AW-1:0] A_INTE  = 6'h0C;
    localparam logic [AW-1:0] A_PTRIG = 6'h10;
    localparam logic [AW-1:0] A_AUX   = 6'h14;
    localparam logic [AW-1:0] A_CTRL  = 6'h18;
    localparam logic [AW-1:0] A_INTS  = 6'h1C;
    localparam logic [AW-1:0] A_ECLK  = 6'h20;
    localparam logic [AW-1:0] A_NEC   = 6'h24;

    logic [DW-1:0] in_q;
    logic [DW-1:0] out_q;
    logic [DW-1:0] oe_q;
    logic [DW-1:0] inte_q;
    logic [DW-1:0] ptrig_q;
    logic [DW-1:0] aux_q;
    logic          ctrl_inte_q;
    logic [DW-1:0] ints_q;
    logic [DW-1:0] eclk_sel_q;
    logic [DW-1:0] nec_q;
    logic          eclk_q;

    logic [AW-1:0] addr;
    logic          we_out;
    logic          we_oe;
    logic          we_inte;
    logic          we_ptrig;
    logic          we_aux;
    logic          we_ctrl;
    logic          we_ints;
    logic          we_eclk;
    logic          we_nec;

    logic          strobe_rise;
    logic          strobe_fall;
    logic [DW-1:0] in_load;
    logic [DW-1:0] next_in;
    logic [DW-1:0] edge_event;
    logic [DW-1:0] next_ints;

    logic          unused_addr_hi;

    assign addr           = bus.gpio_addr[AW-1:0];
    assign unused_addr_hi = ^bus.gpio_addr[DW-1:AW];

    // Per-register write strobes; RGPIO_IN and unmapped offsets have none.
    always_comb begin
        we_out   = 1'b0;
        we_oe    = 1'b0;
        we_inte  = 1'b0;
        we_ptrig = 1'b0;
        we_aux   = 1'b0;
        we_ctrl  = 1'b0;
        we_ints  = 1'b0;
        we_eclk  = 1'b0;
        we_nec   = 1'b0;
        if (bus.gpio_we) begin
            case (addr)
                A_OUT:   we_out   = 1'b1;
                A_OE:    we_oe    = 1'b1;
                A_INTE:  we_inte  = 1'b1;
                A_PTRIG: we_ptrig = 1'b1;
                A_AUX:   we_aux   = 1'b1;
                A_CTRL:  we_ctrl  = 1'b1;
                A_INTS:  we_ints  = 1'b1;
                A_ECLK:  we_eclk  = 1'b1;
                A_NEC:   we_nec   = 1'b1;
                default: ;
            endcase
        end
    end

    // Input sampling: free-running bits load every cycle, strobed bits on the selected eclk edge.
    assign strobe_rise = gpio_eclk & ~eclk_q;
    assign strobe_fall = ~gpio_eclk & eclk_q;

    always_comb begin
        in_load    = '0;
        next_in    = in_q;
        edge_event = '0;
        for (int i = 0; i < DW; i++) begin
            in_load[i] = ~eclk_sel_q[i] | (nec_q[i] ? strobe_fall : strobe_rise);
            next_in[i] = in_load[i] ? in_pad_i[i] : in_q[i];
            edge_event[i] = inte_q[i] &
                            (ptrig_q[i] ? (~in_q[i] & next_in[i])
                                        : (in_q[i] & ~next_in[i]));
        end
    end

    // New events are OR-ed in after a software write so a coincident clear cannot lose them.
    assign next_ints = (we_ints ? bus.gpio_dat_i : ints_q) | edge_event;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            in_q        <= '0;
            out_q       <= '0;
            oe_q        <= '0;
            inte_q      <= '0;
            ptrig_q     <= '0;
            aux_q       <= '0;
            ctrl_inte_q <= 1'b0;
            ints_q      <= '0;
            eclk_sel_q  <= '0;
            nec_q       <= '0;
            eclk_q      <= 1'b0;
        end else begin
            in_q   <= next_in;
            ints_q <= next_ints;
            eclk_q <= gpio_eclk;
            if (we_out)   out_q       <= bus.gpio_dat_i;
            if (we_oe)    oe_q        <= bus.gpio_dat_i;
            if (we_inte)  inte_q      <= bus.gpio_dat_i;
            if (we_ptrig) ptrig_q     <= bus.gpio_dat_i;
            if (we_aux)   aux_q       <= bus.gpio_dat_i;
            if (we_ctrl)  ctrl_inte_q <= bus.gpio_dat_i[0];
            if (we_eclk)  eclk_sel_q  <= bus.gpio_dat_i;
            if (we_nec)   nec_q       <= bus.gpio_dat_i;
        end
    end

    // Zero-latency read mux; CTRL bit 1 reflects pending interrupt status.
    always_comb begin
        bus.gpio_dat_o = '0;
        case (addr)
            A_IN:    bus.gpio_dat_o = in_q;
            A_OUT:   bus.gpio_dat_o = out_q;
            A_OE:    bus.gpio_dat_o = oe_q;
            A_INTE:  bus.gpio_dat_o = inte_q;
            A_PTRIG: bus.gpio_dat_o = ptrig_q;
            A_AUX:   bus.gpio_dat_o = aux_q;
            A_CTRL:  bus.gpio_dat_o = {30'(0), |ints_q, ctrl_inte_q};
            A_INTS:  bus.gpio_dat_o = ints_q;
            A_ECLK:  bus.gpio_dat_o = eclk_sel_q;
            A_NEC:   bus.gpio_dat_o = nec_q;
            default: bus.gpio_dat_o = '0;
        endcase
    end

    assign bus.gpio_inta_o = ctrl_inte_q & (|ints_q);
    assign out_pad_o       = (aux_q & aux_i) | (~aux_q & out_q);
    assign oen_padoe_o     = oe_q;

endmodule

// File: tb/tb_gpio_register.sv
// Directed self-checking bench for gpio_register.
module tb_gpio_register;
    localparam logic [31:0] A_IN    = 32'h00;
    localparam logic [31:0] A_OUT   = 32'h04;
    localparam logic [31:0] A_OE    = 32'h08;
    localparam logic [31:0] A_INTE  = 32'h0C;
    localparam logic [31:0] A_PTRIG = 32'h10;
    localparam logic [31:0] A_AUX   = 32'h14;
    localparam logic [31:0] A_CTRL  = 32'h18;
    localparam logic [31:0] A_INTS  = 32'h1C;
    localparam logic [31:0] A_ECLK  = 32'h20;
    localparam logic [31:0] A_NEC   = 32'h24;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic        gpio_eclk;
    logic [31:0] in_pad_i;
    logic [31:0] aux_i;
    logic [31:0] out_pad_o;
    logic [31:0] oen_padoe_o;

    int checks   = 0;
    int failures = 0;

    gpio_register_if bus ();

    gpio_register dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .bus         (bus),
        .gpio_eclk   (gpio_eclk),
        .in_pad_i    (in_pad_i),
        .aux_i       (aux_i),
        .out_pad_o   (out_pad_o),
        .oen_padoe_o (oen_padoe_o)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge sys_clk);
        bus.gpio_addr  = a;
        bus.gpio_dat_i = d;
        bus.gpio_we    = 1'b1;
        @(posedge sys_clk);
        #1;
        bus.gpio_we    = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus.gpio_addr = a;
        #1;
        check(tag, bus.gpio_dat_o, exp);
    endtask

    initial begin
        logic [31:0] addrs [10];
        addrs = '{A_IN, A_OUT, A_OE, A_INTE, A_PTRIG, A_AUX, A_CTRL, A_INTS, A_ECLK, A_NEC};
        bus.gpio_addr  = '0;
        bus.gpio_dat_i = '0;
        bus.gpio_we    = 1'b0;
        gpio_eclk      = 1'b0;
        in_pad_i       = '0;
        aux_i          = '0;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b1;
        tick();

        // Reset state
        for (int i = 0; i < 10; i++) rd_chk($sformatf("reset_rd_%02h", addrs[i]), addrs[i], 32'h0);
        check("reset_out_pad", out_pad_o, 32'h0);
        check("reset_oen", oen_padoe_o, 32'h0);
        check("reset_inta", 32'(bus.gpio_inta_o), 32'h0);

        // Register read/write
        wr(A_OUT, 32'hAAAA_5555);
        wr(A_OE, 32'hFFFF_0000);
        wr(A_INTE, 32'h5555_AAAA);
        rd_chk("rw_out", A_OUT, 32'hAAAA_5555);
        rd_chk("rw_oe", A_OE, 32'hFFFF_0000);
        rd_chk("rw_inte", A_INTE, 32'h5555_AAAA);
        check("rw_oen_pad", oen_padoe_o, 32'hFFFF_0000);
        wr(A_IN, 32'hFFFF_FFFF);
        rd_chk("rw_in_ro", A_IN, 32'h0);
        wr(32'h28, 32'h1234_5678);
        rd_chk("rw_unmapped", 32'h28, 32'h0);
        rd_chk("rw_out_intact", A_OUT, 32'hAAAA_5555);
        wr(A_INTE, 32'h0);

        // Output mux
        wr(A_OUT, 32'h1234_5678);
        wr(A_AUX, 32'h0);
        check("mux_out_only", out_pad_o, 32'h1234_5678);
        aux_i = 32'hABCD_EF12;
        wr(A_AUX, 32'hFFFF_FFFF);
        check("mux_aux_all", out_pad_o, 32'hABCD_EF12);
        wr(A_AUX, 32'h0000_FFFF);
        check("mux_aux_half", out_pad_o, 32'h1234_EF12);
        wr(A_AUX, 32'h0);

        // Free-running sampling
        @(negedge sys_clk);
        in_pad_i = 32'hDEAD_BEEF;
        rd_chk("samp_before", A_IN, 32'h0);
        tick();
        rd_chk("samp_after", A_IN, 32'hDEAD_BEEF);

        // Rising-strobe sampling
        wr(A_ECLK, 32'hFFFF_FFFF);
        @(negedge sys_clk);
        in_pad_i = 32'hCAFE_BABE;
        tick();
        tick();
        rd_chk("rise_hold", A_IN, 32'hDEAD_BEEF);
        @(negedge sys_clk);
        gpio_eclk = 1'b1;
        rd_chk("rise_pre_edge", A_IN, 32'hDEAD_BEEF);
        tick();
        rd_chk("rise_load", A_IN, 32'hCAFE_BABE);

        // Falling-strobe sampling
        wr(A_NEC, 32'hFFFF_FFFF);
        @(negedge sys_clk);
        in_pad_i = 32'hBEEF_DEAD;
        tick();
        tick();
        rd_chk("fall_hold", A_IN, 32'hCAFE_BABE);
        @(negedge sys_clk);
        gpio_eclk = 1'b0;
        rd_chk("fall_pre_edge", A_IN, 32'hCAFE_BABE);
        tick();
        rd_chk("fall_load", A_IN, 32'hBEEF_DEAD);
        wr(A_ECLK, 32'h0);
        wr(A_NEC, 32'h0);

        // Rising-edge interrupt
        @(negedge sys_clk);
        in_pad_i = 32'h0;
        tick();
        tick();
        wr(A_INTS, 32'h0);
        wr(A_PTRIG, 32'hFF);
        wr(A_INTE, 32'hFF);
        wr(A_CTRL, 32'h1);
        rd_chk("irq_idle_ints", A_INTS, 32'h0);
        check("irq_idle_inta", 32'(bus.gpio_inta_o), 32'h0);
        @(negedge sys_clk);
        in_pad_i = 32'hFF;
        tick();
        rd_chk("irq_rise_ints", A_INTS, 32'h0000_00FF);
        check("irq_rise_inta", 32'(bus.gpio_inta_o), 32'h1);
        rd_chk("irq_rise_ctrl", A_CTRL, 32'h3);
        wr(A_INTS, 32'h0);
        rd_chk("irq_clr_ints", A_INTS, 32'h0);
        check("irq_clr_inta", 32'(bus.gpio_inta_o), 32'h0);
        rd_chk("irq_clr_ctrl", A_CTRL, 32'h1);

        // Global enable off: status still latches
        wr(A_CTRL, 32'h0);
        @(negedge sys_clk);
        in_pad_i = 32'h0;
        tick();
        @(negedge sys_clk);
        in_pad_i = 32'hFF;
        tick();
        rd_chk("irq_gated_ints", A_INTS, 32'h0000_00FF);
        check("irq_gated_inta", 32'(bus.gpio_inta_o), 32'h0);
        rd_chk("irq_gated_ctrl", A_CTRL, 32'h2);

        // Falling-edge interrupt
        wr(A_INTS, 32'h0);
        wr(A_PTRIG, 32'h0);
        @(negedge sys_clk);
        in_pad_i = 32'h0;
        tick();
        rd_chk("irq_fall_ints", A_INTS, 32'h0000_00FF);

        // Clear write colliding with a new event on bit 0
        wr(A_INTS, 32'h0);
        @(negedge sys_clk);
        in_pad_i = 32'h1;
        tick();
        rd_chk("coll_no_rise_evt", A_INTS, 32'h0);
        @(negedge sys_clk);
        in_pad_i       = 32'h0;
        bus.gpio_addr  = A_INTS;
        bus.gpio_dat_i = 32'h0;
        bus.gpio_we    = 1'b1;
        @(posedge sys_clk);
        #1;
        bus.gpio_we    = 1'b0;
        rd_chk("coll_ints", A_INTS, 32'h1);
        wr(A_CTRL, 32'h1);
        check("coll_inta", 32'(bus.gpio_inta_o), 32'h1);

        // Asynchronous reset mid-operation
        wr(A_OUT, 32'h0F0F_0F0F);
        wr(A_OE, 32'h00FF_00FF);
        @(negedge sys_clk);
        #2;
        sys_rst = 1'b0;
        #1;
        check("areset_out_pad", out_pad_o, 32'h0);
        check("areset_oen", oen_padoe_o, 32'h0);
        check("areset_inta", 32'(bus.gpio_inta_o), 32'h0);
        rd_chk("areset_ints", A_INTS, 32'h0);
        rd_chk("areset_ctrl", A_CTRL, 32'h0);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gpio_register.md
# gpio_register

Register file and pad logic of the GPIO controller: a 32-bit memory-mapped register set that drives output pads and enables, samples input pads, and raises a single interrupt on programmable input edges. It sits between the bus-slave front end, which supplies address, write data and write enable, and the GPIO pads. Everything runs on `sys_clk`; `gpio_eclk` is a data input sampled in that domain.

## Interface
No parameters. Data width is fixed at 32.

**Clock and reset**
- sys_clk  in  1  sole clock; all state updates on rising edge.
- sys_rst  in  1  reset, asynchronous, active-low; clears all state.

**Bus side**
- gpio_addr  in  32  byte address; decoded on bits [5:0].
- gpio_dat_i  in  32  write data.
- gpio_we  in  1  write strobe; write occurs at a rising edge while high.
- gpio_dat_o  out  32  read data, combinational mux of the addressed register.
- gpio_inta_o  out  1  interrupt request.

**Pad side**
- gpio_eclk  in  1  external sampling strobe, synchronous to sys_clk.
- in_pad_i  in  32  input pads.
- aux_i  in  32  auxiliary output sources.
- out_pad_o  out  32  output pad values.
- oen_padoe_o  out  32  output enables; 1 = pad driven.

## Operation
**Address map** (other addresses read 0; writes to them ignored):
- 0x00 RGPIO_IN: read-only; writes ignored.
- 0x04 RGPIO_OUT
- 0x08 RGPIO_OE
- 0x0C RGPIO_INTE
- 0x10 RGPIO_PTRIG
- 0x14 RGPIO_AUX
- 0x18 RGPIO_CTRL
- 0x1C RGPIO_INTS
- 0x20 RGPIO_ECLK
- 0x24 RGPIO_NEC

**Outputs**
- out_pad_o = (AUX & aux_i) | (~AUX & OUT), combinational, per bit. It is independent of OE.
- oen_padoe_o = OE.

**Input sampling** (per bit i)
- If ECLK[i]=0: IN[i] <= in_pad_i[i] every cycle.
- If ECLK[i]=1: IN[i] loads in_pad_i[i] only when a strobe occurs.
  - A flop eclk_q <= gpio_eclk every cycle.
  - Rising strobe = gpio_eclk & ~eclk_q. Falling strobe = ~gpio_eclk & eclk_q.
  - NEC[i]=0 selects the rising strobe; NEC[i]=1 selects the falling strobe.

**Interrupts**
- Let next_in be the value IN loads this cycle (IN itself if no load).
- Event[i] = INTE[i] & (PTRIG[i] ? (~IN[i] & next_in[i]) : (IN[i] & ~next_in[i])).
- INTS <= (write to INTS ? gpio_dat_i : INTS) | event. Events win over a simultaneous clear.
- CTRL[0] (INTE) is a R/W global enable.
- CTRL[1] (INTS) is read-only and reads |INTS. Writes to bit 1 are ignored; bits [31:2] read 0.
- gpio_inta_o = CTRL[0] & |INTS, combinational.
- INTS bits latch regardless of CTRL[0]; CTRL[0] gates only gpio_inta_o.

## Timing
- Reset: all registers and eclk_q go to 0. Consequently out_pad_o=0, oen_padoe_o=0, gpio_inta_o=0, and gpio_dat_o reads 0 for every address.
- Write: addr/data/we presented before a rising edge take effect at that edge. The new value is visible on gpio_dat_o and the pads immediately after.
- Read: zero-latency combinational; no read strobe.
- IN with ECLK=0: a pad value is readable after 1 rising edge.
- IN with ECLK=1: loads at the first rising sys_clk edge after the selected gpio_eclk transition, and is readable after that edge.
- Interrupt: INTS and gpio_inta_o assert at the same edge that IN takes the edge-forming value.
- Clearing INTS via write drops gpio_inta_o and CTRL[1] right after the write edge, unless a new event coincides.
- Reset asserted mid-operation clears everything asynchronously. The first post-reset edge behaves as from power-up (eclk_q=0).

## Test plan
1. **Reset.** Release reset, then read all ten addresses → all 0; out_pad_o=0, oen_padoe_o=0, gpio_inta_o=0.
2. **R/W.**
   - Write OUT=AAAA_5555, OE=FFFF_0000, INTE=5555_AAAA → read back identical values; oen_padoe_o=FFFF_0000.
   - Write to IN or 0x28 → no effect.
3. **Output mux.**
   - OUT=1234_5678, AUX=0 → out_pad_o=1234_5678.
   - aux_i=ABCD_EF12, AUX=FFFF_FFFF → out_pad_o=ABCD_EF12.
   - AUX=0000_FFFF → out_pad_o=1234_EF12.
4. **Sampling.**
   - ECLK=0, in_pad_i=DEAD_BEEF → IN reads DEAD_BEEF 1 edge later.
   - ECLK=all ones, NEC=0: change in_pad_i to CAFE_BABE while gpio_eclk is low → IN keeps the old value until the edge after gpio_eclk rises, then reads CAFE_BABE.
   - NEC=all ones: same check on the falling strobe with BEEF_DEAD.
5. **Rising interrupt.**
   - ECLK=0, INTE=FF, PTRIG=FF, CTRL=1. Drive in_pad_i 0 → FF across two edges → INTS=0000_00FF, gpio_inta_o=1, CTRL reads 3.
   - Write INTS=0 → gpio_inta_o=0, CTRL reads 1.
   - With CTRL=0, the same stimulus sets INTS but gpio_inta_o stays 0.
6. **Falling interrupt and collision.**
   - PTRIG=0, in_pad_i FF → 00 → INTS=FF.
   - An INTS clear write coinciding with a new event on bit 0 → INTS=1.
